// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    localparam int DEF_PREAMBLE_W = 8;
    localparam logic [DEF_PREAMBLE_W-1:0] DEF_PREAMBLE = 8'hA5;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word bit buffer: loads a stream word, shifts it out MSB first, and
// truncates the final word to the number of chain bits still outstanding.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int REM_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              intake_en,
    input  logic [REM_W-1:0]  bits_left,
    input  logic              pop,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              take,
    output logic              has_bit,
    output logic              head_bit
);
    localparam int CNT_W = clog2(WORD_W + 1);

    logic [WORD_W-1:0] buffer;
    logic [CNT_W-1:0]  buf_cnt;
    logic [CNT_W-1:0]  load_len;

    // Low-order bits beyond load_len are never shifted out, which discards them.
    assign load_len = (bits_left < REM_W'(WORD_W)) ? CNT_W'(bits_left) : CNT_W'(WORD_W);

    // Accepting while the last bit leaves keeps payload shifting without a bubble.
    assign s_ready  = intake_en &&
                      ((buf_cnt == '0) || ((buf_cnt == CNT_W'(1)) && pop));
    assign take     = s_valid && s_ready;
    assign has_bit  = (buf_cnt != '0);
    assign head_bit = buffer[WORD_W-1];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            buffer  <= '0;
            buf_cnt <= '0;
        end else if (take) begin
            buffer  <= s_data;
            buf_cnt <= load_len;
        end else if (pop) begin
            buffer  <= buffer << 1;
            buf_cnt <= buf_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Drives a configuration chain: shifts a known preamble, then the bitstream,
// and checks the preamble as it emerges from the chain tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int                    CHAIN_LEN  = 128,
    parameter int                    WORD_W     = 8,
    parameter int                    PREAMBLE_W = DEF_PREAMBLE_W,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = DEF_PREAMBLE
) (
    input  logic              prog_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              cfg_error
);
    localparam int TOTAL  = PREAMBLE_W + CHAIN_LEN;
    localparam int SCW    = clog2(TOTAL + 1);
    localparam int NWORDS = ceil_div(CHAIN_LEN, WORD_W);
    localparam int WCW    = clog2(NWORDS + 1);
    localparam int REM_W  = clog2(CHAIN_LEN + WORD_W + 1);

    state_t                state, next_state;
    logic [SCW-1:0]        shift_cnt;
    logic [WCW-1:0]        word_cnt;
    logic [REM_W-1:0]      bits_left;
    logic [PREAMBLE_W-1:0] pre_shifted, chk_shifted;
    logic                  start_load, active, pop, take, has_bit, head_bit;
    logic                  in_window, mismatch;

    assign active     = (state == ST_PREAMBLE) || (state == ST_PAYLOAD);
    assign start_load = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign busy       = active;
    assign done       = (state == ST_DONE);
    assign pop        = (state == ST_PAYLOAD) && has_bit;
    assign bits_left  = REM_W'(CHAIN_LEN) - REM_W'(word_cnt) * REM_W'(WORD_W);

    // MSB of each shifted copy is the preamble bit selected by the count.
    assign pre_shifted = PREAMBLE << shift_cnt;
    assign chk_shifted = PREAMBLE << (shift_cnt - SCW'(CHAIN_LEN));
    assign in_window   = (shift_cnt >= SCW'(CHAIN_LEN));
    assign mismatch    = ccff_shift_en && in_window &&
                         (ccff_tail != chk_shifted[PREAMBLE_W-1]);

    ccff_word_serializer #(
        .WORD_W (WORD_W),
        .REM_W  (REM_W)
    ) u_ser (
        .clk       (prog_clk),
        .reset     (reset),
        .clear     (start_load),
        .intake_en (active && (word_cnt < WCW'(NWORDS))),
        .bits_left (bits_left),
        .pop       (pop),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .take      (take),
        .has_bit   (has_bit),
        .head_bit  (head_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        ccff_shift_en = 1'b0;
        ccff_head     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) next_state = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                ccff_shift_en = 1'b1;
                ccff_head     = pre_shifted[PREAMBLE_W-1];
                if (shift_cnt == SCW'(PREAMBLE_W - 1)) next_state = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                ccff_shift_en = has_bit;
                ccff_head     = head_bit;
                if (has_bit && (shift_cnt == SCW'(TOTAL - 1))) next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (reset) begin
            shift_cnt <= '0;
            word_cnt  <= '0;
            cfg_error <= 1'b0;
        end else if (start_load) begin
            shift_cnt <= '0;
            word_cnt  <= '0;
            cfg_error <= 1'b0;
        end else begin
            if (ccff_shift_en) shift_cnt <= shift_cnt + SCW'(1);
            if (take)          word_cnt  <= word_cnt + WCW'(1);
            if (mismatch)      cfg_error <= 1'b1;
        end
    end

endmodule
